// File: rtl/i2s_tx_seq.sv
// rtl/i2s_tx_seq.sv - I2S transmit sequencer: one-pair sample buffer, frame load, MSB-first serialiser
module i2s_tx_seq #(
    parameter int DATA_W     = 32,
    parameter int UNDR_CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  chl_i,
    input  logic                  sck_i,
    input  logic                  ws_i,
    input  logic                  sample_valid_i,
    output logic                  sample_ready_o,
    input  logic [DATA_W-1:0]     sample_l_i,
    input  logic [DATA_W-1:0]     sample_r_i,
    output logic                  clk_en_o,
    output logic                  sd_o,
    output logic                  busy_o,
    output logic                  underrun_o,
    output logic [UNDR_CNT_W-1:0] underrun_cnt_o
);
    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_RUN, S_DRAIN} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_sck_d;
    logic                  r_ws_d;
    logic                  r_buf_full;
    logic [DATA_W-1:0]     r_buf_l;
    logic [DATA_W-1:0]     r_buf_r;
    logic [DATA_W-1:0]     r_frm_r;
    logic                  r_frm_chl;
    logic [31:0]           r_shift;
    logic                  r_sd;
    logic                  r_undr;
    logic [UNDR_CNT_W-1:0] r_undr_cnt;

    logic                  w_fall;
    logic                  w_ws_chg;
    logic                  w_lstart;
    logic                  w_rstart;
    logic                  w_load;
    logic                  w_push;
    logic                  w_stop;
    logic                  w_shifting;
    logic [DATA_W-1:0]     w_new_l;
    logic [DATA_W-1:0]     w_new_r;

    // 16-bit words are left-justified so the shifter always emits from bit 31
    function automatic logic [31:0] fmt_word(input logic [DATA_W-1:0] w, input logic chl);
        logic [31:0] w32;
        w32 = 32'(w);
        return chl ? w32 : {w32[15:0], 16'h0000};
    endfunction

    assign w_fall     = r_sck_d & ~sck_i;
    assign w_ws_chg   = w_fall & (ws_i != r_ws_d);
    assign w_lstart   = w_ws_chg & ~ws_i;
    assign w_rstart   = w_ws_chg & ws_i;
    assign w_shifting = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_load     = w_lstart & ((r_state == S_RUN) |
                                    (((r_state == S_SYNC) | (r_state == S_DRAIN)) & en_i));
    assign w_stop     = w_lstart & (r_state == S_DRAIN) & ~en_i;
    assign w_push     = sample_valid_i & ~r_buf_full;
    assign w_new_l    = r_buf_full ? r_buf_l : '0;
    assign w_new_r    = r_buf_full ? r_buf_r : '0;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (en_i) w_state_nxt = S_SYNC;
            S_SYNC: begin
                if (!en_i)         w_state_nxt = S_IDLE;
                else if (w_lstart) w_state_nxt = S_RUN;
            end
            S_RUN:   if (!en_i) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (en_i)          w_state_nxt = S_RUN;
                else if (w_lstart) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state    <= S_IDLE;
            r_sck_d    <= 1'b0;
            r_ws_d     <= 1'b0;
            r_buf_full <= 1'b0;
            r_buf_l    <= '0;
            r_buf_r    <= '0;
            r_frm_r    <= '0;
            r_frm_chl  <= 1'b0;
            r_shift    <= '0;
            r_sd       <= 1'b0;
            r_undr     <= 1'b0;
            r_undr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sck_d <= sck_i;
            if (w_fall) r_ws_d <= ws_i;

            // push and consume are exclusive: push needs an empty buffer, consume a full one
            if (w_push) begin
                r_buf_full <= 1'b1;
                r_buf_l    <= sample_l_i;
                r_buf_r    <= sample_r_i;
            end else if (w_load && r_buf_full) begin
                r_buf_full <= 1'b0;
            end

            r_undr <= w_load & ~r_buf_full;
            if (w_load) begin
                r_frm_r   <= w_new_r;
                r_frm_chl <= chl_i;
                if (!r_buf_full && (r_undr_cnt != '1))
                    r_undr_cnt <= r_undr_cnt + UNDR_CNT_W'(1);
            end

            if (r_state == S_IDLE) begin
                r_shift <= '0;
                r_sd    <= 1'b0;
            end else if (w_fall) begin
                // the ws-edge fall still emits the previous word's LSB
                r_sd <= w_stop ? 1'b0 : r_shift[31];
                if (w_load)
                    r_shift <= fmt_word(w_new_l, chl_i);
                else if (w_rstart && w_shifting)
                    r_shift <= fmt_word(r_frm_r, r_frm_chl);
                else
                    r_shift <= {r_shift[30:0], 1'b0};
            end
        end
    end

    assign sample_ready_o = ~r_buf_full;
    assign clk_en_o       = (r_state != S_IDLE);
    assign busy_o         = (r_state != S_IDLE);
    assign sd_o           = r_sd;
    assign underrun_o     = r_undr;
    assign underrun_cnt_o = r_undr_cnt;
endmodule
